// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and helpers for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MC_WAIT    = 2'd3
    } hz_state_t;

    localparam int unsigned REG_ZERO = 0;

    // One extra bit so the largest count value always fits.
    function automatic int hz_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Decode/execute hazard inputs and pipeline control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] i_id_rs1;
    logic [REG_ADDR_W-1:0] i_id_rs2;
    logic                  i_id_uses_rs1;
    logic                  i_id_uses_rs2;
    logic [REG_ADDR_W-1:0] i_idex_rd;
    logic                  i_idex_mem_read;
    logic                  i_branch_taken;
    logic                  i_mc_start;
    logic                  i_mc_done;
    logic                  o_stall;
    logic                  o_flush;
    logic                  o_mc_abort;
    logic                  o_mc_err;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        output i_idex_rd, i_idex_mem_read, i_branch_taken, i_mc_start, i_mc_done,
        input  o_stall, o_flush, o_mc_abort, o_mc_err
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        input  i_idex_rd, i_idex_mem_read, i_branch_taken, i_mc_start, i_mc_done,
        output o_stall, o_flush, o_mc_abort, o_mc_err
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator; x0 never hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [REG_ADDR_W-1:0] i_id_rs1,
    input  wire logic [REG_ADDR_W-1:0] i_id_rs2,
    input  wire logic                  i_id_uses_rs1,
    input  wire logic                  i_id_uses_rs2,
    input  wire logic [REG_ADDR_W-1:0] i_idex_rd,
    input  wire logic                  i_idex_mem_read,
    output logic                       o_load_use
);
    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nonzero = (i_idex_rd != REG_ADDR_W'(REG_ZERO));
    assign w_hit_rs1    = (i_idex_rd == i_id_rs1) && i_id_uses_rs1;
    assign w_hit_rs2    = (i_idex_rd == i_id_rs2) && i_id_uses_rs2;
    assign o_load_use   = i_idex_mem_read && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline stall/flush sequencer with multi-cycle watchdog.
//               Optional HAZARD_STATS_EN adds stall/flush statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int FLUSH_CYCLES      = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MC_TIMEOUT        = 64
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst_n,
    hazard_ctrl_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   o_stall_cycles,
    output logic [31:0]   o_flush_events
`endif
);
    localparam int             c_CNT_W       = hz_cnt_width(FLUSH_CYCLES, LOAD_STALL_CYCLES, MC_TIMEOUT);
    localparam logic [1:0]     c_ST_RUN      = RUN;
    localparam logic [1:0]     c_ST_LOAD     = LOAD_STALL;
    localparam logic [1:0]     c_ST_FLUSH    = FLUSH;
    localparam logic [1:0]     c_ST_MC_WAIT  = MC_WAIT;
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_INI = c_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_INI  = c_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_MC_LAST   = c_CNT_W'(MC_TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mc_err;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               w_load_use;
    logic               w_stall;
    logic               w_flush;
    logic               w_abort;
    logic               w_err_set;
    logic               w_flush_entry;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .i_id_rs1        (bus.i_id_rs1),
        .i_id_rs2        (bus.i_id_rs2),
        .i_id_uses_rs1   (bus.i_id_uses_rs1),
        .i_id_uses_rs2   (bus.i_id_uses_rs2),
        .i_idex_rd       (bus.i_idex_rd),
        .i_idex_mem_read (bus.i_idex_mem_read),
        .o_load_use      (w_load_use)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_stall       = 1'b0;
        w_flush       = 1'b0;
        w_abort       = 1'b0;
        w_err_set     = 1'b0;
        w_flush_entry = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (bus.i_branch_taken) begin
                    w_flush_entry = 1'b1;
                end else if (bus.i_mc_start) begin
                    // cnt holds cycles elapsed since the start cycle (cycle 0)
                    w_stall      = 1'b1;
                    w_next_state = c_ST_MC_WAIT;
                    w_next_cnt   = c_ONE;
                end else if (w_load_use) begin
                    w_stall = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_next_state = c_ST_LOAD;
                        w_next_cnt   = c_LOAD_INI;
                    end
                end
            end
            c_ST_LOAD: begin
                if (bus.i_branch_taken) begin
                    w_flush_entry = 1'b1;
                end else begin
                    w_stall    = 1'b1;
                    w_next_cnt = r_cnt - c_ONE;
                    if (r_cnt == c_ONE) w_next_state = c_ST_RUN;
                end
            end
            c_ST_FLUSH: begin
                w_flush    = 1'b1;
                w_next_cnt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) w_next_state = c_ST_RUN;
            end
            c_ST_MC_WAIT: begin
                w_next_cnt = r_cnt + c_ONE;
                if (bus.i_branch_taken) begin
                    w_abort       = 1'b1;
                    w_flush_entry = 1'b1;
                end else if (bus.i_mc_done) begin
                    w_next_state = c_ST_RUN;
                end else if (r_cnt == c_MC_LAST) begin
                    w_abort      = 1'b1;
                    w_err_set    = 1'b1;
                    w_next_state = c_ST_RUN;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = c_ST_RUN;
        endcase

        if (w_flush_entry) begin
            w_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state = c_ST_FLUSH;
                w_next_cnt   = c_FLUSH_INI;
            end else begin
                w_next_state = c_ST_RUN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= c_ST_RUN;
            r_cnt    <= '0;
            r_mc_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_mc_err <= w_err_set;
        end
    end

    // Gated by reset so a hazard input cannot leak through while held in reset.
    assign bus.o_stall    = w_stall & i_rst_n;
    assign bus.o_flush    = w_flush & i_rst_n;
    assign bus.o_mc_abort = w_abort & i_rst_n;
    assign bus.o_mc_err   = r_mc_err;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush_entry && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed and random self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int RW = 5;
    localparam int FC = 2;
    localparam int LC = 1;
    localparam int MT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(RW)) bus();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    hazard_ctrl #(
        .REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .LOAD_STALL_CYCLES(LC), .MC_TIMEOUT(MT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef HAZARD_STATS_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_flush_events (flush_events)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining flush/stall cycles and age of the multi-cycle op.
    int flush_rem = 0;
    int ld_rem    = 0;
    bit mc_busy   = 0;
    int mc_age    = 0;
    bit err_due   = 0;
    int m_stall_cnt = 0;
    int m_flush_ev  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flush_rem = 0; ld_rem = 0; mc_busy = 0; mc_age = 0; err_due = 0;
        m_stall_cnt = 0; m_flush_ev = 0;
    endtask

    task automatic cyc(input string tag, input bit rst, input bit br, input bit st, input bit dn,
                       input bit mr, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input bit u1, input bit u2);
        bit lu, e_st, e_fl, e_ab, e_err, nxt_err, was_flushing;
        @(negedge clk);
        rst_n = rst;
        bus.i_branch_taken = br; bus.i_mc_start = st; bus.i_mc_done = dn;
        bus.i_idex_mem_read = mr; bus.i_idex_rd = rd; bus.i_id_rs1 = rs1; bus.i_id_rs2 = rs2;
        bus.i_id_uses_rs1 = u1; bus.i_id_uses_rs2 = u2;
        #1;
        lu = mr && (rd != 0) && (((rd == rs1) && u1) || ((rd == rs2) && u2));
        e_st = 0; e_fl = 0; e_ab = 0; nxt_err = 0;
        was_flushing = (flush_rem > 0);
        if (!rst) model_reset();
        e_err = err_due;
        if (rst) begin
            if (flush_rem > 0) begin
                e_fl = 1; flush_rem--;
            end else if (mc_busy) begin
                if (br) begin
                    e_ab = 1; e_fl = 1; flush_rem = FC - 1; mc_busy = 0;
                end else if (dn) begin
                    mc_busy = 0;
                end else if (mc_age == MT - 1) begin
                    e_ab = 1; nxt_err = 1; mc_busy = 0;
                end else begin
                    e_st = 1;
                end
                mc_age++;
            end else if (ld_rem > 0) begin
                if (br) begin
                    e_fl = 1; flush_rem = FC - 1; ld_rem = 0;
                end else begin
                    e_st = 1; ld_rem--;
                end
            end else if (br) begin
                e_fl = 1; flush_rem = FC - 1;
            end else if (st) begin
                e_st = 1; mc_busy = 1; mc_age = 1;
            end else if (lu) begin
                e_st = 1; ld_rem = LC - 1;
            end
        end
        chk({tag, ".stall"}, 32'(bus.o_stall), 32'(e_st));
        chk({tag, ".flush"}, 32'(bus.o_flush), 32'(e_fl));
        chk({tag, ".abort"}, 32'(bus.o_mc_abort), 32'(e_ab));
        chk({tag, ".err"}, 32'(bus.o_mc_err), 32'(e_err));
        chk({tag, ".excl"}, 32'(bus.o_stall & bus.o_flush), 32'd0);
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cycles"}, stall_cycles, 32'(m_stall_cnt));
        chk({tag, ".flush_events"}, flush_events, 32'(m_flush_ev));
        if (e_st) m_stall_cnt++;
        if (e_fl && !was_flushing) m_flush_ev++;
`endif
        err_due = nxt_err;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        #1;
        model_reset();
        chk({tag, ".stall"}, 32'(bus.o_stall), 32'd0);
        chk({tag, ".flush"}, 32'(bus.o_flush), 32'd0);
        chk({tag, ".abort"}, 32'(bus.o_mc_abort), 32'd0);
        chk({tag, ".err"}, 32'(bus.o_mc_err), 32'd0);
    endtask

    int n_stall, abort_at, err_at;

    initial begin
        // Reset held with a branch pending: outputs forced low.
        cyc("rst_hold", 0, 1, 1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        cyc("rst_hold2", 0, 1, 0, 0, 0, '0, '0, '0, 0, 0);
        idle("post_rst");

        // Load-use on rs2: one stall cycle.
        cyc("lu_rs2", 1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
        idle("lu_after");
        cyc("lu_x0", 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        cyc("lu_nouse", 1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0);

        // Branch: two flush cycles; second branch inside the flush is ignored.
        cyc("br1", 1, 1, 0, 0, 0, '0, '0, '0, 0, 0);
        cyc("br2", 1, 1, 0, 0, 0, '0, '0, '0, 0, 0);
        idle("br_end");

        // Multi-cycle op completing five cycles after start.
        n_stall = 0;
        cyc("mc_start", 1, 0, 1, 0, 0, '0, '0, '0, 0, 0);
        n_stall += int'(bus.o_stall);
        for (int i = 0; i < 4; i++) begin
            idle("mc_wait");
            n_stall += int'(bus.o_stall);
        end
        cyc("mc_done", 1, 0, 0, 1, 0, '0, '0, '0, 0, 0);
        n_stall += int'(bus.o_stall);
        chk("mc_stall_len", 32'(n_stall), 32'd5);
        idle("mc_after");

        // Watchdog: no done ever arrives.
        n_stall = 0; abort_at = 0; err_at = 0;
        for (int i = 1; i <= 70; i++) begin
            cyc("mc_to", 1, 0, (i == 1), 0, 0, '0, '0, '0, 0, 0);
            n_stall += int'(bus.o_stall);
            if (bus.o_mc_abort && abort_at == 0) abort_at = i;
            if (bus.o_mc_err && err_at == 0) err_at = i;
        end
        chk("to_stall_len", 32'(n_stall), 32'(MT - 1));
        chk("to_abort_at", 32'(abort_at), 32'(MT));
        chk("to_err_at", 32'(err_at), 32'(MT + 1));

        // Collisions: branch beats load-use, and beats an outstanding op.
        cyc("col_lu", 1, 1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
        idle("col_lu_f");
        cyc("col_mc_st", 1, 0, 1, 0, 0, '0, '0, '0, 0, 0);
        idle("col_mc_w");
        cyc("col_mc_br", 1, 1, 0, 1, 0, '0, '0, '0, 0, 0);
        idle("col_mc_f");
        idle("col_mc_end");

        // Reset mid-FLUSH and mid-MC_WAIT.
        cyc("rf_br", 1, 1, 0, 0, 0, '0, '0, '0, 0, 0);
        rst_n = 1'b0;
        check_all_zero("rst_mid_flush");
        cyc("rf_hold", 0, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        idle("rf_rel1");
        idle("rf_rel2");
        cyc("rm_st", 1, 0, 1, 0, 0, '0, '0, '0, 0, 0);
        idle("rm_w");
        rst_n = 1'b0;
        check_all_zero("rst_mid_mc");
        cyc("rm_hold", 0, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        idle("rm_rel1");
        idle("rm_rel2");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
                1'($urandom), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                RW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
